// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: controller state encoding, the
// default NOP instruction, the PC increment and a word-align helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch control FSM: owns the state register and derives the registered
// valid flag and the combinational imem stop.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   ready_i     - decode accepts the current pair
//   redirect_i  - taken branch/jump/trap this cycle
//   valid_o     - instruction/PC pair valid to decode (registered)
//   stop_o      - freeze imem output register
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one cycle after reset; RESET_PC is on the imem address
// RUN   | imem data matches pc_q; pair is valid, advance on ready
// FLUSH | imem data is from a pre-redirect address; target being issued
module fetch_ctrl_fsm
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ready_i,
  input  logic redirect_i,
  output logic valid_o,
  output logic stop_o
);

  fetch_state_e state_q;
  logic         valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      valid_q <= 1'b0;
    end else if (redirect_i) begin
      // Redirect wins from any state, including FLUSH (re-flush).
      state_q <= FLUSH;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT, RUN, FLUSH: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  // A redirect overrides a stall so the target can be issued immediately.
  assign stop_o  = (state_q == RUN) & ~ready_i & ~redirect_i;

endmodule

// File: rtl/fetch_pc.sv
// Program counter and fetch control ahead of a registered instruction memory.
// Pairs each returned imem word with the PC that fetched it and hands the
// pair to decode over valid/ready; handles stalls, redirect with one-cycle
// flush, misaligned-redirect and out-of-range faults, and an accept counter.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   o_imem_addr       - imem byte address (from next-PC register)
//   o_imem_stop       - freeze imem output register during a stall
//   i_imem_data       - imem word for last cycle's address
//   o_valid, i_ready  - decode handshake
//   o_instr, o_pc     - instruction and its PC
//   i_redirect(_pc)   - redirect request and target
//   o_fault_misalign  - pulse the cycle after a misaligned redirect
//   o_fault_oob       - valid pair whose PC is beyond IMEM_DEPTH
//   o_fetch_cnt       - number of accepted instructions (wraps)
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 2048,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_stop,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault_misalign,
  output logic        o_fault_oob,
  output logic [31:0] o_fetch_cnt
);

  logic        valid;
  logic        stop;
  logic        oob;

  // next_pc_q: address being issued to imem; pc_q: address issued last cycle.
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;

  fetch_ctrl_fsm u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready_i    (i_ready),
    .redirect_i (i_redirect),
    .valid_o    (valid),
    .stop_o     (stop)
  );

  // BOOT, FLUSH and an accepted RUN cycle all advance the same way, so the
  // only cases are redirect, stall (stop) and advance.
  always_comb begin
    next_pc_d = next_pc_q;
    pc_d      = pc_q;
    if (i_redirect) begin
      next_pc_d = word_align(i_redirect_pc);
    end else if (!stop) begin
      pc_d      = next_pc_q;
      next_pc_d = next_pc_q + PC_INC;
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (valid && i_ready && !i_redirect) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  assign misalign_d = i_redirect & (|i_redirect_pc[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_pc_q   <= RESET_PC;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      next_pc_q   <= next_pc_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign oob = valid & ({2'b00, pc_q[31:2]} >= 32'(IMEM_DEPTH));

  assign o_imem_addr      = next_pc_q;
  assign o_imem_stop      = stop;
  assign o_valid          = valid;
  assign o_pc             = pc_q;
  // Out-of-range words stay valid so decode can trap, but carry a NOP.
  assign o_instr          = (valid && !oob) ? i_imem_data : NOP_INSTR;
  assign o_fault_oob      = oob;
  assign o_fault_misalign = misalign_q;
  assign o_fetch_cnt      = fetch_cnt_q;

endmodule
